// File: rtl/icb_sram_responder_pkg.sv
// Shared ICB bus types, widths and the byte-merge helper for the SRAM responder.
package icb_sram_responder_pkg;

  localparam int unsigned ICB_ADDR_W = 32;
  localparam int unsigned ICB_DATA_W = 32;
  localparam int unsigned ICB_MASK_W = 4;

  // Command channel, master to slave
  typedef struct packed {
    logic                  valid;
    logic [ICB_ADDR_W-1:0] addr;
    logic                  read;
    logic [ICB_DATA_W-1:0] wdata;
    logic [ICB_MASK_W-1:0] wmask;
  } icb_cmd_m_t;

  // Command channel, slave to master
  typedef struct packed {
    logic ready;
  } icb_cmd_s_t;

  // Response channel, slave to master
  typedef struct packed {
    logic                  valid;
    logic [ICB_DATA_W-1:0] rdata;
    logic                  err;
  } icb_rsp_s_t;

  // Response channel, master to slave
  typedef struct packed {
    logic ready;
  } icb_rsp_m_t;

  // Payload held in the response buffer
  typedef struct packed {
    logic [ICB_DATA_W-1:0] rdata;
    logic                  err;
  } icb_rsp_data_t;

  // Replace the bytes of old_w selected by mask with the matching bytes of new_w
  function automatic logic [ICB_DATA_W-1:0] byte_merge(input logic [ICB_DATA_W-1:0] old_w,
                                                       input logic [ICB_DATA_W-1:0] new_w,
                                                       input logic [ICB_MASK_W-1:0] mask);
    logic [ICB_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(ICB_MASK_W); i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/icb_sram_responder_rsp_fifo.sv
// Small synchronous FIFO holding responses that could not leave the SRAM output stage.
module icb_rsp_fifo #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = ptr_inc(wptr_q);
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer and occupancy registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/icb_sram_responder.sv
// ICB slave in front of a word-addressed SRAM: byte-masked writes, synchronous reads,
// in-order responses through an output stage plus a small bypassable FIFO.
module icb_sram_responder
  import icb_sram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  icb_cmd_m_t icb_cmd,
  output icb_cmd_s_t icb_cmd_ready,
  output icb_rsp_s_t icb_rsp,
  input  icb_rsp_m_t icb_rsp_ready,
  output logic       idle
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic [ICB_DATA_W-1:0] mem_q [MEM_WORDS];

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  stg_valid_q, stg_valid_d;
  logic [ICB_DATA_W-1:0] stg_rdata_q, stg_rdata_d;
  logic                  stg_err_q, stg_err_d;

  logic [31:2]           off_w;
  logic                  in_range, cmd_err;
  logic [IdxW-1:0]       idx;
  logic                  accept, wr_en, rsp_hs;

  logic                  fifo_empty, fifo_full, fifo_push, fifo_pop, bypass;
  icb_rsp_data_t         fifo_wdata, fifo_rdata;

  // Word-granular offset; BASE_ADDR is word aligned so the low two bits never borrow
  assign off_w    = icb_cmd.addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (icb_cmd.addr >= BASE_ADDR) && (off_w[31:IdxW+2] == '0);
  assign idx      = off_w[IdxW+1:2];
  assign cmd_err  = !in_range || (icb_cmd.addr[1:0] != 2'b00);

  // rst_n gates the registered credit so ready drops during the very first reset cycle
  assign icb_cmd_ready.ready = ready_q && rst_n;
  assign accept = icb_cmd.valid && icb_cmd_ready.ready;
  assign wr_en  = accept && !icb_cmd.read && !cmd_err;
  assign idle   = (cnt_q == '0);

  // The oldest response lives in the FIFO if any; otherwise the output stage bypasses it
  assign bypass    = fifo_empty && stg_valid_q && icb_rsp_ready.ready;
  assign fifo_pop  = !fifo_empty && icb_rsp_ready.ready;
  assign fifo_push = stg_valid_q && !bypass && (!fifo_full || fifo_pop);
  assign fifo_wdata.rdata = stg_rdata_q;
  assign fifo_wdata.err   = stg_err_q;

  icb_rsp_fifo #(
    .Depth (RSP_DEPTH - 1),
    .Width ($bits(icb_rsp_data_t))
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Response mux; data forced to zero whenever nothing is presented
  always_comb begin
    icb_rsp = '0;
    icb_rsp.valid = !fifo_empty || stg_valid_q;
    if (!fifo_empty) begin
      icb_rsp.rdata = fifo_rdata.rdata;
      icb_rsp.err   = fifo_rdata.err;
    end else if (stg_valid_q) begin
      icb_rsp.rdata = stg_rdata_q;
      icb_rsp.err   = stg_err_q;
    end
  end

  assign rsp_hs = icb_rsp.valid && icb_rsp_ready.ready;

  // Outstanding credit count and the registered ready it produces
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rsp_hs)      cnt_d = cnt_q + 1'b1;
    else if (!accept && rsp_hs) cnt_d = cnt_q - 1'b1;
    ready_d = (cnt_d < CntW'(RSP_DEPTH));
  end

  // Output stage: captures the SRAM read (or write/error ack) of an accepted command.
  // Credits guarantee the stage has already drained whenever a new command is accepted.
  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_rdata_d = stg_rdata_q;
    stg_err_d   = stg_err_q;
    if (bypass || fifo_push) stg_valid_d = 1'b0;
    if (accept) begin
      stg_valid_d = 1'b1;
      stg_err_d   = cmd_err;
      stg_rdata_d = (icb_cmd.read && !cmd_err) ? mem_q[idx] : '0;
    end
  end

  // Control and response-stage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      stg_valid_q <= 1'b0;
      stg_rdata_q <= '0;
      stg_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      stg_valid_q <= stg_valid_d;
      stg_rdata_q <= stg_rdata_d;
      stg_err_q   <= stg_err_d;
    end
  end

  // SRAM byte-masked write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= byte_merge(mem_q[idx], icb_cmd.wdata, icb_cmd.wmask);
  end

endmodule
